ipp_mem_stream_reader: RTL and testbench

- Read-DMA stage directly downstream of a processor's on-chip image memory: 32-bit words, 14-bit word address, 10000 words, single port, 1-cycle read latency.
- On a start command it reads a contiguous word range from the memory port and emits the words in order on a ready/valid stream toward the pixel-processing pipeline.
- Absorbs the memory read latency and downstream backpressure with a small credit-controlled FIFO, so the memory is never read faster than the consumer accepts.

---
 rtl/ipp_stream_pkg.sv | 23 ++
 rtl/ipp_sync_fifo.sv | 68 ++++++
 rtl/ipp_mem_stream_reader.sv | 154 +++++++++++++++
 tb/tb_ipp_mem_stream_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipp_stream_pkg.sv
// Shared types and constants for the image-memory stream stages.
package ipp_stream_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 14;
    localparam int MEM_WORDS = 10000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // One buffered word plus its end-of-transfer marker.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/ipp_sync_fifo.sv
// Small synchronous FIFO with flush and an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle;
// a pop while empty is ignored. Flush wins over push and pop.
module ipp_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Qualify requests against the current occupancy.
    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count < CNT_W'(DEPTH)) || pop_ok);
    end

    assign pop_data = mem[rd_ptr];

    // Storage, pointers and count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ipp_mem_stream_reader.sv
// Read-DMA: streams a contiguous word range out of the single-port image
// memory (1-cycle read latency) onto a ready/valid stream.
// Stream handshake: a word transfers on every clock edge where
// out_valid && out_ready; once out_valid is high it stays high with
// out_data/out_last unchanged until that transfer (abort/reset excepted).
// Reads are credit-limited so fifo entries plus in-flight reads never exceed
// FIFO_DEPTH, hence the memory is never read ahead of the consumer.
module ipp_mem_stream_reader
    import ipp_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_e            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] remaining;
    logic              inflight;
    logic              inflight_last;
    logic              error_q;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    credit_used;
    logic [ADDR_W:0]   end_sum;
    logic              range_ok;
    logic              pop;
    logic              issue;
    logic              abort_now;
    logic              last_issue;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;

    // Handshake, credit and start-range decode.
    always_comb begin
        pop         = out_valid && out_ready;
        credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
        issue       = (state == ST_RUN) && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
        last_issue  = issue && (remaining == ADDR_W'(1));
        abort_now   = abort && ((state == ST_RUN) || (state == ST_DRAIN));
        end_sum     = {1'b0, base_addr} + {1'b0, word_count};
        range_ok    = (end_sum <= (ADDR_W + 1)'(MEM_WORDS));
        push_entry  = '{data: mem_readdata, last: inflight_last};
    end

    ipp_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (abort_now),
        .push      (inflight),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    // Transfer FSM: command acceptance, address/count tracking, read tagging.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            addr          <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            error_q       <= 1'b0;
            // A read strobed in the abort cycle is dropped, not captured.
            inflight      <= issue && !abort_now;
            inflight_last <= last_issue;
            if (issue) begin
                remaining <= remaining - ADDR_W'(1);
                // Hold on the final address so it never runs past the memory.
                if (!last_issue) begin
                    addr <= addr + ADDR_W'(1);
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_count == '0) begin
                            state <= ST_DONE;
                        end else if (range_ok) begin
                            state     <= ST_RUN;
                            addr      <= base_addr;
                            remaining <= word_count;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (last_issue) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (!inflight && (fifo_count == CNT_W'(pop))) begin
                        // Last word leaves on this edge; done follows next cycle.
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state and FIFO head.
    always_comb begin
        busy           = (state != ST_IDLE);
        done           = (state == ST_DONE);
        error          = error_q;
        mem_address    = addr;
        mem_chipselect = issue;
        mem_clken      = 1'b1;
        out_valid      = (fifo_count != '0);
        out_data       = out_valid ? head.data : '0;
        out_last       = out_valid && head.last;
        dbg_state      = state;
    end

endmodule

// File: tb/tb_ipp_mem_stream_reader.sv
// Directed bench for the image-memory stream reader.
module tb_ipp_mem_stream_reader;
    import ipp_stream_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              out_ready = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] word_count = '0;
    logic [DATA_W-1:0] mem_readdata = '0;
    logic              busy, done, error, mem_chipselect, mem_clken;
    logic              out_valid, out_last;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        dbg_state;

    ipp_mem_stream_reader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .abort          (abort),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset / memory model ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
    end

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a, 2'b01, ~a, 2'b10};
    endfunction

    initial forever begin
        @(posedge clk);
        if (mem_chipselect) mem_readdata <= mem_word(mem_address);
    end

    // ---------------- scoreboard ----------------
    int chk_cnt = 0;
    int fail_cnt = 0;
    logic [DATA_W:0]   exp_q[$];
    int                strobes, pops, done_cnt, err_cnt;
    int                done_cyc, err_cyc, last_hs_cyc, first_strobe_cyc, last_strobe_cyc;
    logic              busy_seen;
    logic [ADDR_W-1:0] exp_addr;
    logic              stab_en = 1'b1;
    logic              prev_stall = 1'b0;
    logic [DATA_W:0]   prev_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        strobes = 0; pops = 0; done_cnt = 0; err_cnt = 0;
        done_cyc = -1; err_cyc = -1; last_hs_cyc = -1;
        first_strobe_cyc = -1; last_strobe_cyc = -1;
        busy_seen = 1'b0; prev_stall = 1'b0;
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (reset_n) begin
            if (stab_en && prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", {out_data, out_last}, prev_out);
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_data, out_last};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", {out_data, out_last}, 64'h0);
                    fail_cnt += (out_data === '0 && out_last === 1'b0) ? 1 : 0;
                end else begin
                    check("word", {out_data, out_last}, exp_q.pop_front());
                end
                pops++;
                last_hs_cyc = cyc;
            end
            if (mem_chipselect) begin
                check("strobe_addr", mem_address, exp_addr);
                exp_addr++;
                strobes++;
                if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
                last_strobe_cyc = cyc;
                check("credit_bound", (strobes - pops) <= 2, 1'b1);
            end
            if (done)  begin done_cnt++; done_cyc = cyc; end
            if (error) begin err_cnt++;  err_cyc  = cyc; end
            if (busy)  busy_seen = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string             name;
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] cnt;
        logic [7:0]        pat;      // out_ready pattern, bit k%8 in cycle k
        logic              inj;      // pulse a second start mid-transfer
        logic              exp_err;
        logic              exp_done;
        int                exp_strobes;
    } vec_t;

    task automatic run_xfer(input vec_t v);
        int start_cyc;
        bit finished;
        finished = 1'b0;
        clear_sb();
        exp_addr = v.base;
        if (!v.exp_err) begin
            for (int i = 0; i < int'(v.cnt); i++) begin
                exp_q.push_back({mem_word(v.base + ADDR_W'(i)), (i == int'(v.cnt) - 1)});
            end
        end
        base_addr  = v.base;
        word_count = v.cnt;
        out_ready  = v.pat[0];
        start      = 1'b1;
        start_cyc  = cyc;
        step();
        start = 1'b0;
        for (int k = 1; k < 300 && !finished; k++) begin
            out_ready = v.pat[k % 8];
            if (v.inj && k == 3) begin
                start      = 1'b1;
                base_addr  = 14'h0010;
                word_count = 14'd2;
            end
            step();
            start = 1'b0;
            if (done_cnt != 0 || err_cnt != 0) finished = 1'b1;
        end
        check({v.name, "_complete"}, finished, 1'b1);
        check({v.name, "_busy_after"}, busy, 1'b0);
        check({v.name, "_done_width"}, done, 1'b0);
        check({v.name, "_error"}, err_cnt, v.exp_err);
        check({v.name, "_done"}, done_cnt, v.exp_done);
        check({v.name, "_strobes"}, strobes, v.exp_strobes);
        check({v.name, "_words_left"}, exp_q.size(), 0);
        check({v.name, "_busy_seen"}, busy_seen, !v.exp_err);
        if (v.exp_err) check({v.name, "_err_cycle"}, err_cyc, start_cyc + 1);
        if (v.exp_done && v.cnt == 0) check({v.name, "_done_cycle"}, done_cyc, start_cyc + 1);
        if (v.exp_done && v.cnt != 0) check({v.name, "_done_latency"}, done_cyc, last_hs_cyc + 1);
        if (v.pat == 8'hFF && v.exp_strobes > 1)
            check({v.name, "_strobe_span"}, last_strobe_cyc - first_strobe_cyc, v.exp_strobes - 1);
        out_ready = 1'b0;
        step();
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[8];

    initial begin
        vecs[0] = '{"basic",     14'h0100, 14'd4,  8'hFF, 1'b0, 1'b0, 1'b1, 4};
        vecs[1] = '{"backpress", 14'h0000, 14'd16, 8'h69, 1'b0, 1'b0, 1'b1, 16};
        vecs[2] = '{"zero",      14'h0050, 14'd0,  8'hFF, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{"oob",       14'd9998, 14'd3,  8'hFF, 1'b0, 1'b1, 1'b0, 0};
        vecs[4] = '{"top_edge",  14'd9997, 14'd3,  8'hFF, 1'b0, 1'b0, 1'b1, 3};
        vecs[5] = '{"busy_start",14'h0500, 14'd6,  8'hFF, 1'b1, 1'b0, 1'b1, 6};
        vecs[6] = '{"alt_ready", 14'h0020, 14'd5,  8'h55, 1'b0, 1'b0, 1'b1, 5};
        vecs[7] = '{"single",    14'h0000, 14'd1,  8'hFF, 1'b0, 1'b0, 1'b1, 1};

        clear_sb();
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 32'h0);
        check("rst_last", out_last, 1'b0);
        check("rst_cs", mem_chipselect, 1'b0);
        check("rst_addr", mem_address, 14'h0);
        check("rst_clken", mem_clken, 1'b1);
        check("rst_state", dbg_state, 2'd0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) run_xfer(vecs[i]);

        // Abort with a full buffer, then a fresh transfer from a new base.
        clear_sb();
        exp_addr   = 14'h0200;
        base_addr  = 14'h0200;
        word_count = 14'd8;
        out_ready  = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check("abort_pre_valid", out_valid, 1'b1);
        check("abort_pre_head", {out_data, out_last}, {mem_word(14'h0200), 1'b0});
        check("abort_pre_strobes", strobes, 2);
        abort   = 1'b1;
        stab_en = 1'b0;
        step();
        abort = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_state", dbg_state, 2'd0);
        repeat (4) step();
        check("abort_no_done", done_cnt, 0);
        check("abort_no_error", err_cnt, 0);
        check("abort_no_more_reads", strobes, 2);
        check("abort_still_empty", out_valid, 1'b0);
        stab_en = 1'b1;
        run_xfer('{"post_abort", 14'h0300, 14'd3, 8'hFF, 1'b0, 1'b0, 1'b1, 3});

        // Asynchronous reset mid-transfer.
        clear_sb();
        exp_addr = 14'h0040;
        for (int i = 0; i < 10; i++) exp_q.push_back({mem_word(14'h0040 + ADDR_W'(i)), (i == 9)});
        base_addr  = 14'h0040;
        word_count = 14'd10;
        out_ready  = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("mid_busy", busy, 1'b1);
        check("mid_valid", out_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_data", out_data, 32'h0);
        check("arst_last", out_last, 1'b0);
        check("arst_cs", mem_chipselect, 1'b0);
        check("arst_addr", mem_address, 14'h0);
        check("arst_clken", mem_clken, 1'b1);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        check("post_rst_valid", out_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);
        stab_en = 1'b1;
        run_xfer('{"post_reset", 14'h0070, 14'd2, 8'hFF, 1'b0, 1'b0, 1'b1, 2});

        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
